// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer: FSM states and reset-cause codes,
// plus the saturating tick-counter increment.
package reset_pkg;

  typedef enum logic [2:0] {
    WAIT_PWR,
    PORESET,
    HRESET,
    RELEASE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_REQ = 2'b01,
    CAUSE_PWR = 2'b10,
    CAUSE_TMO = 2'b11
  } cause_t;

  // Tick counter holds at all-ones instead of wrapping back to a state-ending value.
  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchroniser for an asynchronous level input, cleared to 0 by rst_n.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Board reset sequencer: drives PORESET# then HRESET#, waits for the SoC to release HRESET#.
// Optional macro RESET_SEQ_TIMEOUT_EN enables the HRESET# release timeout and timeout_err.
module reset_seq
  import reset_pkg::*;
#(
  parameter logic [7:0] PORESET_CNT     = 8'd4,
  parameter logic [7:0] HRESET_CNT      = 8'd2,
  parameter logic [7:0] RELEASE_TIMEOUT = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       reset_req,
  input  logic       pwr_good,
  input  logic       hreset_in_n,
  output logic       poreset_n,
  output logic       hreset_oe,
  output logic       busy,
  output logic       req_ack,
  output logic [1:0] cause,
  output logic       timeout_err
);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic reset_req_s, pwr_good_s, hreset_in_n_s;

  sync2 u_sync_req  (.clk(clk), .rst_n(rst_n), .d(reset_req),   .q(reset_req_s));
  sync2 u_sync_pwr  (.clk(clk), .rst_n(rst_n), .d(pwr_good),    .q(pwr_good_s));
  sync2 u_sync_hrst (.clk(clk), .rst_n(rst_n), .d(hreset_in_n), .q(hreset_in_n_s));

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       restart, ack_nx, terr_nx;
  logic [1:0] cause_nx;

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    ack_nx   = 1'b0;
    cause_nx = cause;
    terr_nx  = timeout_err;
    // Power loss beats a request, which beats normal sequencing.
    if (state != WAIT_PWR && !pwr_good_s) begin
      state_nx = WAIT_PWR;
      cause_nx = CAUSE_PWR;
    end else if (state != WAIT_PWR && reset_req_s) begin
      state_nx = PORESET;
      restart  = 1'b1;
      ack_nx   = 1'b1;
      cause_nx = CAUSE_REQ;
    end else begin
      case (state)
        WAIT_PWR: if (pwr_good_s) state_nx = PORESET;
        PORESET:  if (ce && cnt == PORESET_CNT - 8'd1) state_nx = HRESET;
        HRESET:   if (ce && cnt == HRESET_CNT - 8'd1) state_nx = RELEASE;
        RELEASE: begin
          if (hreset_in_n_s) begin
            state_nx = RUN;
          end else if (TMO_EN && ce && cnt == RELEASE_TIMEOUT - 8'd1) begin
            state_nx = PORESET;
            cause_nx = CAUSE_TMO;
            terr_nx  = 1'b1;
          end
        end
        RUN:      state_nx = RUN;
        default:  state_nx = WAIT_PWR;
      endcase
    end
    if (state_nx != state || restart) cnt_nx = 8'd0;
    else if (ce)                      cnt_nx = cnt_inc(cnt);
    else                              cnt_nx = cnt;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_PWR;
      cnt         <= 8'd0;
      poreset_n   <= 1'b0;
      hreset_oe   <= 1'b1;
      busy        <= 1'b1;
      req_ack     <= 1'b0;
      cause       <= CAUSE_POR;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      poreset_n   <= !(state_nx inside {WAIT_PWR, PORESET});
      hreset_oe   <= state_nx inside {WAIT_PWR, PORESET, HRESET};
      busy        <= state_nx != RUN;
      req_ack     <= ack_nx;
      cause       <= cause_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Randomised and directed bench for reset_seq against a tick-counting phase model.
module tb_reset_seq;

  localparam int P_CNT = 4;
  localparam int H_CNT = 2;
  localparam int R_TMO = 16;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam int PH_OFF = 0, PH_POR = 1, PH_HR = 2, PH_REL = 3, PH_RUN = 4;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic reset_req = 1'b0, pwr_good = 1'b1, hreset_in_n = 1'b1;
  logic poreset_n, hreset_oe, busy, req_ack, timeout_err;
  logic [1:0] cause;

  int total = 0, bad = 0, ack_cnt = 0;
  bit ce_rand = 1'b0;

  always #5 clk = ~clk;

  reset_seq dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .reset_req(reset_req), .pwr_good(pwr_good),
    .hreset_in_n(hreset_in_n), .poreset_n(poreset_n), .hreset_oe(hreset_oe), .busy(busy),
    .req_ack(req_ack), .cause(cause), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus ticks elapsed in that phase; pads seen two edges late.
  int ph = PH_OFF, ticks = 0;
  bit m_ack = 1'b0, m_terr = 1'b0;
  bit [1:0] m_cause = 2'b00, pg_h = 2'b00, rq_h = 2'b00, hi_h = 2'b00;

  initial begin : model
    bit s_pg, s_rq, s_hi;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = PH_OFF; ticks = 0; m_ack = 0; m_cause = 2'b00; m_terr = 0;
        pg_h = 0; rq_h = 0; hi_h = 0;
      end else begin
        s_pg = pg_h[1]; s_rq = rq_h[1]; s_hi = hi_h[1];
        pg_h = {pg_h[0], pwr_good};
        rq_h = {rq_h[0], reset_req};
        hi_h = {hi_h[0], hreset_in_n};
        m_ack = 0;
        if (ph != PH_OFF && !s_pg) begin
          ph = PH_OFF; ticks = 0; m_cause = 2'b10;
        end else if (ph != PH_OFF && s_rq) begin
          ph = PH_POR; ticks = 0; m_ack = 1; m_cause = 2'b01;
        end else if (ph == PH_OFF) begin
          if (s_pg) begin ph = PH_POR; ticks = 0; end
        end else if (ph == PH_POR) begin
          if (ce) ticks++;
          if (ticks == P_CNT) begin ph = PH_HR; ticks = 0; end
        end else if (ph == PH_HR) begin
          if (ce) ticks++;
          if (ticks == H_CNT) begin ph = PH_REL; ticks = 0; end
        end else if (ph == PH_REL) begin
          if (s_hi) begin
            ph = PH_RUN; ticks = 0;
          end else if (TMO) begin
            if (ce) ticks++;
            if (ticks == R_TMO) begin ph = PH_POR; ticks = 0; m_cause = 2'b11; m_terr = 1; end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("poreset_n", 8'(poreset_n), 8'(!(ph == PH_OFF || ph == PH_POR)));
      check("hreset_oe", 8'(hreset_oe), 8'(ph == PH_OFF || ph == PH_POR || ph == PH_HR));
      check("busy", 8'(busy), 8'(ph != PH_RUN));
      check("req_ack", 8'(req_ack), 8'(m_ack));
      check("cause", 8'(cause), 8'(m_cause));
      check("timeout_err", 8'(timeout_err), 8'(m_terr));
      if (req_ack === 1'b1) ack_cnt++;
    end
  end

  initial begin : ce_gen
    int div = 0;
    forever begin
      @(negedge clk);
      if (ce_rand) ce = 1'($urandom_range(0, 1));
      else begin
        ce = (div == 3);
        div = (div + 1) % 4;
      end
    end
  end

  function automatic bit in_kind(input int k);
    case (k)
      0:       return busy === 1'b0;
      1:       return poreset_n === 1'b1 && hreset_oe === 1'b1;
      2:       return hreset_oe === 1'b0 && busy === 1'b1;
      default: return poreset_n === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int kind, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_kind(kind) && n < budget);
    if (!in_kind(kind)) begin
      total++; bad++;
      $display("FAIL wait_%s: condition not reached within %0d clk", name, budget);
    end
  endtask

  task automatic req_pulse(input int len);
    reset_req = 1'b1;
    repeat (len) @(negedge clk);
    reset_req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    wait_for("por_run", 0, 400);
    check("por_cause", 8'(cause), 8'd0);
    check("por_busy", 8'(busy), 8'd0);
    check("por_poreset_n", 8'(poreset_n), 8'd1);
    check("por_hreset_oe", 8'(hreset_oe), 8'd0);

    // Three-clock request: one ack per synchronised cycle.
    ack_cnt = 0;
    req_pulse(3);
    repeat (4) @(negedge clk);
    check("req_ack_count", 8'(ack_cnt), 8'd3);
    check("req_cause", 8'(cause), 8'd1);
    check("req_poreset_n", 8'(poreset_n), 8'd0);
    wait_for("req_run", 0, 400);
    check("req_run_cause", 8'(cause), 8'd1);

    // Power loss in HRESET.
    req_pulse(1);
    wait_for("pl_hreset", 1, 400);
    pwr_good = 1'b0;
    repeat (2) @(negedge clk);
    check("pl_not_yet", 8'(poreset_n), 8'd1);
    @(negedge clk);
    check("pl_poreset_n", 8'(poreset_n), 8'd0);
    check("pl_hreset_oe", 8'(hreset_oe), 8'd1);
    check("pl_cause", 8'(cause), 8'd2);
    repeat (5) @(negedge clk);
    pwr_good = 1'b1;
    wait_for("pl_run", 0, 400);
    check("pl_run_cause", 8'(cause), 8'd2);

    // Restart from RELEASE.
    hreset_in_n = 1'b0;
    req_pulse(1);
    wait_for("rs_release", 2, 400);
    req_pulse(1);
    repeat (2) @(negedge clk);
    check("rs_ack", 8'(req_ack), 8'd1);
    check("rs_poreset_n", 8'(poreset_n), 8'd0);
    check("rs_cause", 8'(cause), 8'd1);

    // Release stall with HRESET# held low by the SoC.
    wait_for("st_release", 2, 400);
    if (TMO) begin
      wait_for("st_timeout", 3, 120);
      check("st_terr", 8'(timeout_err), 8'd1);
      check("st_cause", 8'(cause), 8'd3);
      hreset_in_n = 1'b1;
      wait_for("st_run", 0, 400);
      check("st_terr_sticky", 8'(timeout_err), 8'd1);
    end else begin
      repeat (420) @(negedge clk);
      check("st_busy", 8'(busy), 8'd1);
      check("st_hreset_oe", 8'(hreset_oe), 8'd0);
      check("st_poreset_n", 8'(poreset_n), 8'd1);
      check("st_terr", 8'(timeout_err), 8'd0);
      hreset_in_n = 1'b1;
      wait_for("st_run", 0, 400);
    end

    // Asynchronous reset in HRESET.
    req_pulse(1);
    wait_for("ar_hreset", 1, 400);
    #1 rst_n = 1'b0;
    #1;
    check("ar_poreset_n", 8'(poreset_n), 8'd0);
    check("ar_hreset_oe", 8'(hreset_oe), 8'd1);
    check("ar_busy", 8'(busy), 8'd1);
    check("ar_req_ack", 8'(req_ack), 8'd0);
    check("ar_cause", 8'(cause), 8'd0);
    check("ar_terr", 8'(timeout_err), 8'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_for("ar_run", 0, 400);
    check("ar_run_cause", 8'(cause), 8'd0);

    // Random stimulus against the model.
    ce_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_req = ($urandom_range(0, 29) == 0);
      if (pwr_good) begin
        if ($urandom_range(0, 149) == 0) pwr_good = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        pwr_good = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) hreset_in_n = ~hreset_in_n;
      if ($urandom_range(0, 799) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    reset_req = 1'b0;
    pwr_good = 1'b1;
    hreset_in_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Board reset sequencer and the consumer of the latched, extended reset request.
- Takes the request, plus a power-good input, and drives the SoC reset lines in a fixed, timed order: PORESET# first, then HRESET#.
- After driving HRESET# it releases the line and waits for the SoC to release it too.
- Sits beside the request latch in the CPLD top level and shares its `ce` tick prescaler.
- Returns a one-cycle acknowledge for each request it accepts.

Parameters:
- PORESET_CNT, 8'd4: number of ce ticks PORESET# is held low. Must be ≥1.
- HRESET_CNT, 8'd2: number of ce ticks HRESET# stays driven low after PORESET# is released. Must be ≥1.
- RELEASE_TIMEOUT, 8'd16: number of ce ticks allowed for the SoC to release HRESET#. Used only with RESET_SEQ_TIMEOUT_EN.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: tick enable; all counters advance only when ce=1.
- reset_req, in, 1: active-high reset request. Asynchronous; synchronised internally by 2 FFs.
- pwr_good, in, 1: power rails OK. Asynchronous; synchronised internally by 2 FFs.
- hreset_in_n, in, 1: observed HRESET# pad level. Asynchronous; synchronised internally by 2 FFs.
- poreset_n, out, 1: PORESET# drive.
- hreset_oe, out, 1: 1 means pull HRESET# low; 0 means tristate.
- busy, out, 1: 1 in every state except RUN.
- req_ack, out, 1: one-clk pulse when a request is accepted.
- cause, out, 2: last reset cause. 00 = power-on, 01 = request, 10 = power loss, 11 = release timeout.
- timeout_err, out, 1: sticky release-timeout flag.

Behaviour:
- Reset values (rst_n=0): state=WAIT_PWR, poreset_n=0, hreset_oe=1, busy=1, req_ack=0, cause=00, timeout_err=0, cnt=0, sync FFs=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Synchronised inputs are used 2 clk after the pad changes.
- cnt is 8 bit, clears on every state entry, and increments on ce only. It never wraps: a parameter of N ends a state on the ce where cnt==N-1.
- State WAIT_PWR: poreset_n=0, hreset_oe=1. Go to PORESET when pwr_good_s=1.
- State PORESET: poreset_n=0, hreset_oe=1. Go to HRESET after PORESET_CNT ticks.
- State HRESET: poreset_n=1, hreset_oe=1. Go to RELEASE after HRESET_CNT ticks.
- State RELEASE: poreset_n=1, hreset_oe=0. Go to RUN when hreset_in_n_s=1.
- State RUN: poreset_n=1, hreset_oe=0, busy=0. Go to PORESET when reset_req_s=1.
- Priority 1: pwr_good_s=0 in any state other than WAIT_PWR → WAIT_PWR. Sets cause=10 and overrides everything else in that cycle.
- Priority 2: reset_req_s=1 in RUN, PORESET, HRESET or RELEASE → PORESET with cnt=0. Also pulses req_ack and sets cause=01.
  - A request during a sequence therefore restarts it.
  - A request in WAIT_PWR is ignored: no ack, no cause change.
- Level semantics: a held reset_req restarts PORESET every clk, so HRESET is never reached until the request drops. The upstream latch clears on extend completion, so the request is bounded.
- req_ack is asserted for exactly one clk per restart edge.
  - Held reset_req gives one ack per cycle; the bench counts this as expected.
  - The upstream latch treats the first ack as the one it consumes.
- Power-on: cause=00 persists until the first event. A WAIT_PWR→PORESET transition does not modify cause.
- ce=0 throughout: the sequence stalls in its current counting state. Synchronised-input transitions (power-good, request, HRESET# release) still act.

Optional Feature:
- Macro: RESET_SEQ_TIMEOUT_EN.
- Defined: in RELEASE, cnt counts ce ticks. If RELEASE_TIMEOUT ticks elapse with hreset_in_n_s=0:
  - go to PORESET;
  - set cause=11;
  - set timeout_err=1, which is sticky until rst_n.
  - No req_ack is issued for a timeout.
- Undefined: RELEASE waits indefinitely, timeout_err is tied to 0, and cause never takes the value 11.

Decomposition:
- Shared package reset_pkg holds:
  - state enum: WAIT_PWR, PORESET, HRESET, RELEASE, RUN;
  - cause encodings: CAUSE_POR, CAUSE_REQ, CAUSE_PWR, CAUSE_TMO.
- One sub-module: sync2, a 2-FF synchroniser with async reset to 0, instantiated three times.
- The FSM and counter stay in reset_seq.

Test Plan (defaults, ce every 4th clk):
- Power-on: rst_n released, pwr_good=1 → poreset_n low for 4 ce ticks, then hreset_oe=1 for 2 more ticks, then hreset_oe=0. With hreset_in_n=1, RUN is reached, busy=0, cause=00.
- Request: in RUN, pulse reset_req for 3 clk → req_ack pulses, cause=01, poreset_n=0 for 4 ticks, full sequence back to RUN.
- Power loss: drop pwr_good during HRESET → WAIT_PWR 2 clk later with poreset_n=0, hreset_oe=1, cause=10. Restore pwr_good → full sequence.
- Restart: reset_req during RELEASE → back to PORESET with cnt=0, and the PORESET low time is again 4 ticks.
- Release stall: hold hreset_in_n=0 in RELEASE.
  - With RESET_SEQ_TIMEOUT_EN: after 16 ticks → PORESET, timeout_err=1, cause=11, and timeout_err remains 1 after a later successful RUN.
  - Without the macro: the block stays in RELEASE for 100 ticks.
- Async reset mid-sequence: assert rst_n=0 in HRESET → all outputs take reset values immediately, without waiting for a clock edge.
